dmem_responder: RTL and testbench

Byte-masked data memory responder at the far end of the load/store path. It accepts word-aligned requests carrying the 4-bit byte-lane mask and lane-replicated store data produced by the load/store alignment stage. It commits enabled byte lanes on writes and returns the raw 32-bit word on reads; sign/zero extension stays in the load aligner. A valid/ready handshake on both request and response lets the core stall on memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_byte_bank.sv | 18 +
 rtl/dmem_responder.sv | 65 ++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, legal byte-lane masks and word width
package dmem_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    localparam logic [3:0] MASK_B0  = 4'b0001;
    localparam logic [3:0] MASK_B1  = 4'b0010;
    localparam logic [3:0] MASK_B2  = 4'b0100;
    localparam logic [3:0] MASK_B3  = 4'b1000;
    localparam logic [3:0] MASK_H01 = 4'b0011;
    localparam logic [3:0] MASK_H12 = 4'b0110;
    localparam logic [3:0] MASK_H23 = 4'b1100;
    localparam logic [3:0] MASK_W   = 4'b1111;
    function automatic logic mask_legal(input logic [3:0] mask);
        return mask inside {MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H01, MASK_H12, MASK_H23, MASK_W};
    endfunction
endpackage

// File: rtl/dmem_byte_bank.sv
// dmem_byte_bank: one byte lane of data memory, synchronous write and registered read
module dmem_byte_bank #(
    parameter int DEPTH = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    d,
    output logic [7:0]    q
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= d;
        if (re) q <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-masked data memory with valid/ready request and response handshakes
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_mask,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = ADDR_W - 2;
    localparam int BW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_t state;
    logic [IW-1:0] idx;
    logic [WORD_W-1:0] q;
    logic fire, bad, st, ld, unused_lane_bits;
    assign idx = req_addr[ADDR_W-1:2];
    assign unused_lane_bits = ^req_addr[1:0];
    assign fire = req_valid && state == IDLE;
    assign bad = !mask_legal(req_mask) || 32'(idx) >= 32'(DEPTH);
    assign st = fire && !bad && req_we;
    assign ld = fire && !bad && !req_we;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        dmem_byte_bank #(.DEPTH(DEPTH), .AW(BW)) u_bank (
            .clk (clk),
            .we  (st && req_mask[i]),
            .re  (ld),
            .addr(idx[BW-1:0]),
            .d   (req_wdata[8*i+:8]),
            .q   (q[8*i+:8])
        );
    end
    // the bank's registered read lands in q during READ, so rsp_rdata is captured one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else if (state == IDLE) begin
            if (fire) begin
                rsp_rdata <= '0;
                rsp_err <= bad;
                state <= (bad || req_we) ? RESP : READ;
            end
        end else if (state == READ) begin
            rsp_rdata <= q;
            rsp_err <= 1'b0;
            state <= RESP;
        end else if (rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, corner sequences and randomized traffic against a word-level model
module tb_dmem_responder;
    localparam int DEPTH = 512;
    localparam int NW = 32;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
    logic [11:0] req_addr = '0;
    logic [3:0] req_mask = '0;
    logic [31:0] req_wdata = '0, rsp_rdata;
    int n_chk = 0, n_fail = 0;
    logic poke = 0;
    logic [31:0] model [NW];

    dmem_responder #(.ADDR_W(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // legal = a single contiguous run of 1, 2 or 4 lanes
    function automatic logic legal_ref(input logic [3:0] m);
        int ones = $countones(m);
        int lo = 0;
        logic [3:0] run;
        if (m == 0) return 0;
        while (!m[lo]) lo++;
        run = 4'(((1 << ones) - 1) << lo);
        return m == run && ones != 3;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] b = 0;
        for (int i = 0; i < 4; i++) if (m[i]) b |= 32'hFF << (8 * i);
        return b;
    endfunction

    // entered and left at posedge+1; response held for 'stall' cycles before being consumed
    task automatic txn(input logic we, input logic [11:0] addr, input logic [3:0] mask, input logic [31:0] wd,
                       input int stall, output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        rsp_ready = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_mask = mask; req_wdata = wd;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        for (int s = 0; s < stall; s++) begin
            req_valid = poke; req_we = 1; req_mask = 4'hF; req_wdata = ~rd;
            @(posedge clk); #1;
            chk("hold", {31'd0, rsp_valid, req_ready, rsp_err, rsp_rdata}, {31'd0, 1'b1, 1'b0, er, rd});
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic ref_txn(input logic we, input int word, input logic [3:0] mask, input logic [31:0] wd, input int stall);
        logic [31:0] rd, erd;
        logic er, ok;
        int lat, elat;
        logic [11:0] addr = 12'(word * 4 + $urandom_range(0, 3));
        ok = legal_ref(mask) && word < DEPTH;
        erd = (ok && !we) ? model[word] : 32'd0;
        elat = (ok && !we) ? 2 : 1;
        txn(we, addr, mask, wd, stall, rd, er, lat);
        if (ok && we) model[word] = (model[word] & ~lanes(mask)) | (wd & lanes(mask));
        chk("rand_rdata", rd, erd);
        chk("rand_err", er, !ok);
        chk("rand_lat", lat, elat);
    endtask

    vec_t tbl [12];
    logic [31:0] rd;
    logic er;
    int lat;

    initial begin
        tbl[0]  = '{1, 12'h010, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 1};
        tbl[1]  = '{0, 12'h010, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 2};
        tbl[2]  = '{1, 12'h012, 4'b0100, 32'hAAAAAAAA, 32'h0, 0, 1};
        tbl[3]  = '{0, 12'h010, 4'b1111, 32'h0, 32'hDEAABEEF, 0, 2};
        tbl[4]  = '{1, 12'h011, 4'b0110, 32'h12345678, 32'h0, 0, 1};
        tbl[5]  = '{0, 12'h010, 4'b1111, 32'h0, 32'hDE3456EF, 0, 2};
        tbl[6]  = '{1, 12'h020, 4'b1111, 32'h11223344, 32'h0, 0, 1};
        tbl[7]  = '{1, 12'h020, 4'b0101, 32'hFFFFFFFF, 32'h0, 1, 1};
        tbl[8]  = '{0, 12'h020, 4'b1111, 32'h0, 32'h11223344, 0, 2};
        tbl[9]  = '{1, 12'h800, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, 1};
        tbl[10] = '{0, 12'h800, 4'b1111, 32'h0, 32'h0, 1, 1};
        tbl[11] = '{0, 12'h023, 4'b0001, 32'h0, 32'h11223344, 0, 2};
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        foreach (tbl[k]) begin
            txn(tbl[k].we, tbl[k].addr, tbl[k].mask, tbl[k].wd, 0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", k), rd, tbl[k].rd);
            chk($sformatf("vec%0d_err", k), er, tbl[k].err);
            chk($sformatf("vec%0d_lat", k), lat, tbl[k].lat);
        end
        // backpressure: response held 5 cycles while a competing store is presented
        poke = 1;
        txn(0, 12'h010, 4'b1111, 32'h0, 5, rd, er, lat);
        poke = 0;
        chk("bp_rdata", rd, 32'hDE3456EF);
        chk("bp_ready_after", req_ready, 1);
        txn(0, 12'h010, 4'b1111, 32'h0, 0, rd, er, lat);
        chk("bp_ignored_store", rd, 32'hDE3456EF);
        // reset while in READ
        txn(1, 12'h030, 4'b1111, 32'hCAFEF00D, 0, rd, er, lat);
        req_valid = 1; req_we = 0; req_addr = 12'h030; req_mask = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        chk("in_read", {req_ready, rsp_valid}, 2'b00);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_read_valid", rsp_valid, 0);
        chk("rst_read_ready", req_ready, 1);
        chk("rst_read_rdata", rsp_rdata, 0);
        txn(0, 12'h030, 4'b1111, 32'h0, 0, rd, er, lat);
        chk("rst_keeps_store", rd, 32'hCAFEF00D);
        // randomized traffic against the model
        for (int w = 0; w < NW; w++) begin
            model[w] = $urandom;
            txn(1, 12'(w * 4), 4'hF, model[w], 0, rd, er, lat);
        end
        for (int t = 0; t < 300; t++) begin
            int w = $urandom_range(0, NW + 7);
            ref_txn($urandom_range(0, 1) == 1, w >= NW ? DEPTH + w - NW : w, 4'($urandom), $urandom, $urandom_range(0, 2));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
